sub_bytes_state_seq: RTL and testbench
======================================

SUB_BYTES_STATE_SEQ -- requirements
Module: sub_bytes_state_seq

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset. Ports are listed below.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  state_in/round_in carry a block to transform.
REQ-005 in_ready  output  1  block can accept input this cycle.
REQ-006 state_in  input  128  AES state; byte 0 = [127:120], word 0 = [127:96].
REQ-007 round_in  input  4  round tag travelling with the state.
REQ-008 out_valid  output  1  state_out/round_out hold a finished result.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 state_out  output  128  forward SubBytes (FIPS-197 S-box) of the accepted state.
REQ-011 round_out  output  4  round_in captured at acceptance.

Function
REQ-012 SHALL be the encryption-direction counterpart of the inverse SubBytes path: it applies the forward S-box to every byte and passes the round tag through unchanged.
REQ-013 SHALL implement the FSM states IDLE, SUB and DONE.
REQ-014 IDLE: in_ready=1. On an edge with in_valid=1, SHALL latch state_in into the source register, latch round_in, clear word counter cnt to 0, and go to SUB.
REQ-015 SUB: in_ready=0. Each edge SHALL write S-box(source word cnt) into result word cnt, then increment cnt (2 bits). Word order is 0,1,2,3 (MSW first).
REQ-016 SUB SHALL exit to DONE on the edge where cnt=3. cnt wraps to 0.
REQ-017 DONE: out_valid=1 and in_ready=0. On an edge with out_ready=1, SHALL return to IDLE and clear out_valid.
REQ-018 Latency: for acceptance at edge E0, result words are written at E1 through E4, and out_valid is high from E4 until the handshake.
REQ-019 Throughput: at most one block per 6 cycles when out_ready is held at 1.
REQ-020 state_out and round_out SHALL stay stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-021 Changes on state_in, round_in or in_valid after acceptance SHALL NOT affect the result in flight.
REQ-022 in_valid while in SUB or DONE SHALL be ignored. No input is captured and there is no error.
REQ-023 out_ready while not in DONE SHALL have no effect.
REQ-024 state_out SHALL show the result register at all times. Its value is defined only while out_valid=1.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, cnt=0, out_valid=0, state_out=0 and round_out=0. in_ready SHALL be 1 after release.
REQ-026 Reset during SUB or DONE SHALL discard the block in flight. No partial result is ever presented.
REQ-027 The first acceptance SHALL be possible on the first rising edge after rst_n rises.

Structure
REQ-028 Shared package aes_pkg SHALL hold:
- the 256-entry forward S-box constant table;
- STATE_W=128, WORD_W=32, ROUND_W=4;
- the FSM state encoding (IDLE, SUB, DONE).
REQ-029 The combinational 4-byte forward substitution SHALL be the single sub-module sub_bytes_four_fwd. It is instantiated once and fed by a cnt-selected 32-bit mux of the source register.

Verification
REQ-030 Stimulus: reset; state_in = 128'h0, round_in = 4'h5 -> required: out_valid rises 4 edges after acceptance, state_out = 128'h6363...63, round_out = 4'h5.
REQ-031 Stimulus: state_in = 00112233445566778899aabbccddeeff -> required: state_out = 638293c31bfc33f5c4eeacea4bc12816.
REQ-032 Stimulus: out_ready held at 0 for 10 cycles in DONE, with in_valid=1 and a new state_in throughout -> required: state_out and round_out unchanged, in_ready=0; after out_ready=1 for one edge, the FSM returns to IDLE and accepts the pending input on the next edge.
REQ-033 Stimulus: rst_n pulsed low at edge E2 of a block -> required: out_valid=0, state_out=0 and in_ready=1 immediately; the next block ff..ff yields 1616...16 with normal latency.
REQ-034 Stimulus: 8 back-to-back blocks with random data and round tags, out_ready=1 -> required: every result matches the reference S-box model, round tags are preserved in order, and blocks complete at 6-cycle spacing.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: datapath widths, sequencer state encoding and the
// forward S-box used by the encryption-direction SubBytes path.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int WORD_W  = 32;
  localparam int ROUND_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/sub_bytes_four_fwd.sv
// Combinational forward S-box applied to the four bytes of one 32-bit word.
module sub_bytes_four_fwd
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] sub_word
);

  // Substitute each byte independently; byte lanes keep their positions.
  always_comb begin
    sub_word = '0;
    for (int i = 0; i < WORD_W / 8; i++) begin
      sub_word[8*i +: 8] = sbox_lookup(word[8*i +: 8]);
    end
  end

endmodule

// File: rtl/sub_bytes_state_seq.sv
// Word-serial forward SubBytes over a 128-bit AES state. One shared 4-byte
// substitution unit processes words 0..3 (most significant first) over four
// cycles, then the result is held until the downstream handshake.
module sub_bytes_state_seq
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  input  logic [ROUND_W-1:0] round_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic [ROUND_W-1:0] round_out
);

  fsm_state_t         state_q;
  fsm_state_t         state_d;
  logic [STATE_W-1:0] src_q;
  logic [STATE_W-1:0] res_q;
  logic [ROUND_W-1:0] round_q;
  logic [1:0]         cnt_q;
  logic [WORD_W-1:0]  sel_word;
  logic [WORD_W-1:0]  sub_word;

  // Pick the source word addressed by the word counter (word 0 is the MSW).
  always_comb begin
    sel_word = '0;
    case (cnt_q)
      2'd0:    sel_word = src_q[127:96];
      2'd1:    sel_word = src_q[95:64];
      2'd2:    sel_word = src_q[63:32];
      default: sel_word = src_q[31:0];
    endcase
  end

  sub_bytes_four_fwd u_sub_four (
    .word     (sel_word),
    .sub_word (sub_word)
  );

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; out_valid is only ever raised in DONE,
  // so a partially written result register is never presented.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = SUB;
        end
      end
      SUB: begin
        if (cnt_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture on acceptance, then write one substituted word per SUB cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= '0;
      res_q   <= '0;
      round_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            src_q   <= state_in;
            round_q <= round_in;
            cnt_q   <= 2'd0;
          end
        end
        SUB: begin
          case (cnt_q)
            2'd0:    res_q[127:96] <= sub_word;
            2'd1:    res_q[95:64]  <= sub_word;
            2'd2:    res_q[63:32]  <= sub_word;
            default: res_q[31:0]   <= sub_word;
          endcase
          cnt_q <= cnt_q + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign state_out = res_q;
  assign round_out = round_q;

endmodule

// File: tb/tb_sub_bytes_state_seq.sv
// Self-checking bench for sub_bytes_state_seq. Expected results come from an
// S-box rebuilt from GF(2^8) inversion plus the FIPS-197 affine transform.
module tb_sub_bytes_state_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_in = '0;
  logic [3:0]   round_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] state_out;
  logic [3:0]   round_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] ref_sbox [256];

  sub_bytes_state_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .round_in  (round_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .round_out (round_out)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter used to measure block spacing.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r = 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (gf_mul(a, 8'(x)) == 8'h01) r = 8'(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_state_ref(input logic [127:0] s);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_sbox[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [127:0] s, input logic [3:0] r);
    in_valid = 1'b1;
    state_in = s;
    round_in = r;
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic run_block(input string tag, input logic [127:0] s, input logic [3:0] r);
    int lat;
    check_output({tag, " ready_before"}, in_ready, 1);
    apply_stimulus(s, r);
    tick();
    in_valid = 1'b0;
    state_in = rand128();
    round_in = ~r;
    check_output({tag, " busy"}, in_ready, 0);
    wait_out_valid(lat);
    check_output({tag, " latency"}, lat, 4);
    check_output({tag, " state"}, state_out, sub_state_ref(s));
    check_output({tag, " round"}, round_out, r);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output({tag, " valid_cleared"}, out_valid, 0);
    check_output({tag, " ready_after"}, in_ready, 1);
  endtask

  initial begin
    logic [127:0] a_blk, p_blk, held;
    logic [3:0]   a_rnd, p_rnd;
    logic [127:0] d [8];
    logic [3:0]   rt [8];
    int acc [8];
    int done [8];
    int lat, waited;

    for (int i = 0; i < 256; i++) ref_sbox[i] = affine(gf_inv(8'(i)));

    // Reset state, with in_valid asserted to show it is ignored under reset.
    rst_n = 1'b0;
    in_valid = 1'b1;
    state_in = rand128();
    tick();
    tick();
    check_output("rst out_valid", out_valid, 0);
    check_output("rst state_out", state_out, 0);
    check_output("rst round_out", round_out, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_output("rst in_ready", in_ready, 1);

    // All-zero block accepted on the first edge after release.
    run_block("zero", 128'h0, 4'h5);
    check_output("zero literal", state_out, {16{8'h63}});

    // Known-answer vector.
    run_block("kat", 128'h00112233445566778899aabbccddeeff, 4'h9);
    check_output("kat literal", state_out, 128'h638293c31bfc33f5c4eeacea4bc12816);

    // Backpressure in DONE with a pending input held throughout.
    a_blk = rand128();
    a_rnd = 4'(3);
    p_blk = rand128();
    p_rnd = 4'(12);
    apply_stimulus(a_blk, a_rnd);
    tick();
    apply_stimulus(rand128(), 4'hf);
    wait_out_valid(lat);
    check_output("bp latency", lat, 4);
    check_output("bp state", state_out, sub_state_ref(a_blk));
    held = sub_state_ref(a_blk);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(rand128(), 4'(i));
      tick();
      check_output("bp hold state", state_out, held);
      check_output("bp hold round", round_out, a_rnd);
      check_output("bp hold in_ready", in_ready, 0);
      check_output("bp hold out_valid", out_valid, 1);
    end
    apply_stimulus(p_blk, p_rnd);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output("bp release valid", out_valid, 0);
    check_output("bp release ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_output("bp pending accepted", in_ready, 0);
    wait_out_valid(lat);
    check_output("bp pending latency", lat, 4);
    check_output("bp pending state", state_out, sub_state_ref(p_blk));
    check_output("bp pending round", round_out, p_rnd);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of a block.
    apply_stimulus(rand128(), 4'h3);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_output("midrst out_valid", out_valid, 0);
    check_output("midrst state_out", state_out, 0);
    check_output("midrst round_out", round_out, 0);
    check_output("midrst in_ready", in_ready, 1);
    #2;
    rst_n = 1'b1;
    run_block("ones", {128{1'b1}}, 4'ha);
    check_output("ones literal", state_out, {16{8'h16}});

    // Eight back-to-back random blocks with out_ready held high.
    for (int k = 0; k < 8; k++) begin
      d[k] = rand128();
      rt[k] = 4'($urandom_range(0, 15));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(d[k], rt[k]);
      waited = 0;
      while (!in_ready && waited < 20) begin
        tick();
        waited++;
      end
      check_output("b2b ready", in_ready, 1);
      tick();
      acc[k] = cyc;
      apply_stimulus(rand128(), 4'($urandom_range(0, 15)));
      wait_out_valid(lat);
      done[k] = cyc;
      check_output("b2b latency", lat, 4);
      check_output("b2b state", state_out, sub_state_ref(d[k]));
      check_output("b2b round", round_out, rt[k]);
      if (k > 0) begin
        check_output("b2b accept spacing", acc[k] - acc[k-1], 6);
        check_output("b2b done spacing", done[k] - done[k-1], 6);
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check_output("b2b final idle", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
